// File: rtl/key_scan_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner.
package key_scan_pkg;

  localparam int NROW   = 4;
  localparam int NCOL   = 4;
  localparam int NKEY   = NROW * NCOL;
  localparam int CODE_W = 4;

  localparam logic [NROW-1:0] ROW_RST = 4'b1110;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CODE_W-1:0] f_low_idx(input logic [NKEY-1:0] m);
    f_low_idx = '0;
    for (int i = NKEY - 1; i >= 0; i--)
      if (m[i]) f_low_idx = CODE_W'(i);
  endfunction

endpackage

// File: rtl/key_scan_sync2.sv
// Two-flop synchronizer with a configurable width and reset value.
module key_scan_sync2 #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: row strobing, full-map debounce and press-event encoding.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int BW  = 6,
  parameter int DBW = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BW-1:0]     TIMEOUT,
  input  logic [DBW-1:0]    DB_N,
  input  logic [NCOL-1:0]   COL,
  output logic [NROW-1:0]   ROW_T,
  output logic [NKEY-1:0]   KEY_STATE,
  output logic              KEY_PRESS,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_ANY
);

  logic [NCOL-1:0]   w_col;
  logic [BW-1:0]     r_slot;
  logic [1:0]        r_row;
  logic [NROW-1:0]   r_row_t;
  logic [NKEY-1:0]   r_raw;
  logic [NKEY-1:0]   r_prev;
  logic [DBW-1:0]    r_stable;
  logic [NKEY-1:0]   r_state;
  logic [NKEY-1:0]   r_pend;
  logic              r_press;
  logic [CODE_W-1:0] r_code;
  logic              r_any;

  logic              w_sample;
  logic              w_scan_end;
  logic              w_same;
  logic              w_commit;
  logic [1:0]        w_row_nxt;
  logic [NKEY-1:0]   w_raw_nxt;
  logic [NKEY-1:0]   w_state_nxt;
  logic [NKEY-1:0]   w_newpress;
  logic [NKEY-1:0]   w_low;

  key_scan_sync2 #(
    .W       (NCOL),
    .RST_VAL ({NCOL{1'b1}})
  ) u_col_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (COL),
    .o_q   (w_col)
  );

  assign w_sample   = (r_slot == TIMEOUT);
  assign w_scan_end = w_sample && (r_row == 2'(NROW - 1));
  assign w_row_nxt  = r_row + 2'd1;

  // The last row's sample is folded in combinationally so the scan-end
  // compare sees the complete map on the same edge it is captured.
  always_comb begin
    w_raw_nxt = r_raw;
    if (w_sample) w_raw_nxt[r_row*NCOL +: NCOL] = ~w_col;
  end

  assign w_same      = (w_raw_nxt == r_prev);
  assign w_commit    = w_scan_end && w_same && (r_stable == DB_N - DBW'(1));
  assign w_state_nxt = w_commit ? w_raw_nxt : r_state;
  assign w_newpress  = w_commit ? (w_raw_nxt & ~r_state) : '0;
  assign w_low       = r_pend & (~r_pend + NKEY'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slot  <= '0;
      r_row   <= '0;
      r_row_t <= ROW_RST;
      r_raw   <= '0;
    end else begin
      r_raw <= w_raw_nxt;
      if (w_sample) begin
        r_slot  <= '0;
        r_row   <= w_row_nxt;
        r_row_t <= ~(NROW'(1) << w_row_nxt);
      end else begin
        r_slot  <= r_slot + BW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev   <= '0;
      r_stable <= '0;
      r_state  <= '0;
      r_any    <= 1'b0;
    end else begin
      if (w_scan_end) begin
        r_prev <= w_raw_nxt;
        if (!w_same)              r_stable <= '0;
        else if (r_stable < DB_N) r_stable <= r_stable + DBW'(1);
      end
      r_state <= w_state_nxt;
      r_any   <= |w_state_nxt;
    end
  end

  // One event per cycle, lowest index first; new presses merge into the mask.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend  <= '0;
      r_press <= 1'b0;
      r_code  <= '0;
    end else begin
      r_pend  <= (r_pend & ~w_low) | w_newpress;
      r_press <= |r_pend;
      if (|r_pend) r_code <= f_low_idx(r_pend);
    end
  end

  assign ROW_T     = r_row_t;
  assign KEY_STATE = r_state;
  assign KEY_PRESS = r_press;
  assign KEY_CODE  = r_code;
  assign KEY_ANY   = r_any;

endmodule

// File: tb/tb_key_scan.sv
// Keypad scanner bench: vector table, directed corner sequences, random keys vs scan-level model.
module tb_key_scan;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [5:0]  TIMEOUT = 6'd3;
  logic [3:0]  DB_N = 4'd2;
  logic [3:0]  COL;
  logic [3:0]  ROW_T;
  logic [15:0] KEY_STATE;
  logic        KEY_PRESS;
  logic [3:0]  KEY_CODE;
  logic        KEY_ANY;

  key_scan #(.BW(6), .DBW(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TIMEOUT   (TIMEOUT),
    .DB_N      (DB_N),
    .COL       (COL),
    .ROW_T     (ROW_T),
    .KEY_STATE (KEY_STATE),
    .KEY_PRESS (KEY_PRESS),
    .KEY_CODE  (KEY_CODE),
    .KEY_ANY   (KEY_ANY)
  );

  always #5 CLK = ~CLK;

  // Physical keypad: a pressed key shorts its column to any row driven low.
  logic [15:0] pressed = '0;
  always_comb begin
    COL = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!ROW_T[r]) COL = COL & ~pressed[r*4 +: 4];
  end

  typedef struct { int cyc; logic [3:0] code; } ev_t;
  typedef struct { logic [15:0] keys; int scans; logic [15:0] exp; } vec_t;

  ev_t         evq[$];
  logic [15:0] hist [0:16383];
  int          cyc, n_chk, n_err, n_pulse;
  logic [15:0] m_prev, m_state;
  int          m_run;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scan-level model: a scan's map is what each row saw two cycles before its
  // sample point; the map is accepted once DB_N+1 consecutive scans agree.
  task automatic model_scan_end();
    logic [15:0] snap, newp;
    int base, n;
    base = cyc - 16;
    for (int r = 0; r < 4; r++) snap[r*4 +: 4] = hist[base + 4*r + 1][r*4 +: 4];
    if (snap == m_prev) m_run++; else m_run = 1;
    m_prev = snap;
    if (m_run == int'(DB_N) + 1) begin
      newp = snap & ~m_state;
      m_state = snap;
      n = 0;
      for (int k = 0; k < 16; k++)
        if (newp[k]) begin
          evq.push_back('{cyc: cyc + 1 + n, code: 4'(k)});
          n++;
        end
    end
    chk("key_state", KEY_STATE, m_state);
    chk("key_any", 16'(KEY_ANY), 16'(|m_state));
  endtask

  task automatic cycle_checks();
    logic [3:0] er;
    er = ~(4'b0001 << ((cyc / 4) % 4));
    chk("row_t", 16'(ROW_T), 16'(er));
    if (cyc > 0 && cyc % 16 == 0) model_scan_end();
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      chk("key_press", 16'(KEY_PRESS), 16'd1);
      chk("key_code", 16'(KEY_CODE), 16'(evq[0].code));
      void'(evq.pop_front());
    end else begin
      chk("key_press_idle", 16'(KEY_PRESS), 16'd0);
    end
    if (KEY_PRESS) n_pulse++;
  endtask

  task automatic step();
    if (cyc < 16384) hist[cyc] = pressed;
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc >= 16384) begin
      $display("FAIL cycle_budget: got %0d expected below 16384", cyc);
      $fatal(1, "cycle budget exceeded");
    end
    cycle_checks();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_row_t", 16'(ROW_T), 16'h000E);
    chk("rst_state", KEY_STATE, 16'h0000);
    chk("rst_press", 16'(KEY_PRESS), 16'd0);
    chk("rst_code", 16'(KEY_CODE), 16'd0);
    chk("rst_any", 16'(KEY_ANY), 16'd0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    m_prev = '0;
    m_state = '0;
    m_run = 1;
    evq.delete();
    cycle_checks();
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m;
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = 16'(1) << $urandom_range(0, 15);
      2:       m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      default: m = 16'($urandom);
    endcase
    return m;
  endfunction

  vec_t tbl [10];
  int   p0;

  initial begin
    n_chk = 0; n_err = 0; n_pulse = 0; cyc = 0;
    tbl[0] = '{16'h0000, 2, 16'h0000};
    tbl[1] = '{16'h0040, 2, 16'h0000};
    tbl[2] = '{16'h0040, 1, 16'h0040};
    tbl[3] = '{16'h0040, 2, 16'h0040};
    tbl[4] = '{16'h0000, 2, 16'h0040};
    tbl[5] = '{16'h0000, 1, 16'h0000};
    tbl[6] = '{16'h8421, 3, 16'h8421};
    tbl[7] = '{16'hFFFF, 3, 16'hFFFF};
    tbl[8] = '{16'h0001, 3, 16'h0001};
    tbl[9] = '{16'h0000, 3, 16'h0000};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      pressed = tbl[i].keys;
      repeat (16 * tbl[i].scans) step();
      chk("tbl_state", KEY_STATE, tbl[i].exp);
      chk("tbl_any", 16'(KEY_ANY), 16'(|tbl[i].exp));
    end

    // Two keys in one update: back-to-back events, lowest code first.
    pressed = 16'h2002;
    repeat (48) step();
    chk("k113_state", KEY_STATE, 16'h2002);
    step();
    chk("k113_press1", 16'(KEY_PRESS), 16'd1);
    chk("k113_code1", 16'(KEY_CODE), 16'd1);
    step();
    chk("k113_press2", 16'(KEY_PRESS), 16'd1);
    chk("k113_code2", 16'(KEY_CODE), 16'd13);
    step();
    chk("k113_idle", 16'(KEY_PRESS), 16'd0);
    chk("k113_hold", 16'(KEY_CODE), 16'd13);
    repeat (13) step();
    p0 = n_pulse;
    pressed = 16'h0000;
    repeat (48) step();
    chk("release_pulses", 16'(n_pulse - p0), 16'd0);
    chk("release_any", 16'(KEY_ANY), 16'd0);

    // Bounce: key 6 toggles every 20 cycles, then settles pressed.
    p0 = n_pulse;
    for (int t = 0; t < 200; t++) begin
      pressed = ((t / 20) % 2 == 0) ? 16'h0040 : 16'h0000;
      step();
    end
    chk("bounce_pulses", 16'(n_pulse - p0), 16'd0);
    chk("bounce_state", KEY_STATE, 16'h0000);
    pressed = 16'h0040;
    repeat (40) step();
    chk("bounce_early", KEY_STATE, 16'h0000);
    repeat (16) step();
    chk("bounce_settle", KEY_STATE, 16'h0040);

    // Reset at row 2 slot 1 with a key held, then debounce from scratch.
    repeat (9) step();
    do_reset();
    repeat (32) step();
    chk("rst_restart_early", KEY_STATE, 16'h0000);
    repeat (16) step();
    chk("rst_restart", KEY_STATE, 16'h0040);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) pressed = rand_mask();
      step();
    end

    DB_N = 4'd1;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) pressed = rand_mask();
      step();
    end

    DB_N = 4'd3;
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) pressed = rand_mask();
      step();
    end
    repeat (40) step();
    chk("events_drained", 16'(evq.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
